// File: rtl/seq_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_1_pkg
//  Description : Shared types for the seq_1 a->b->c sequence monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_1_pkg;

    // Progress through the a, b, c pattern.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_A  = 2'd1,
        GOT_AB = 2'd2
    } state_t;

endpackage : seq_1_pkg
`default_nettype wire

// File: rtl/seq_1.sv
`default_nettype none
// ============================================================================
//  Module      : seq_1
//  Description : Watches a, b, c on consecutive samples and emits a one-cycle
//                registered pulse on x when c arrives qualified by y.
//                e clears to IDLE, d stalls progress; e has priority over d.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_1
    import seq_1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic y,
    output logic x
);

    state_t r_state;
    state_t w_state_next;
    logic   w_x_next;

    // State and match pulse registers; reset forces IDLE and drops x at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            x       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            x       <= w_x_next;
        end
    end

    // Next-state and next-x decode: clear, then stall, then pattern tracking.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = 1'b0;
        if (e) begin
            w_state_next = IDLE;
        end else if (d) begin
            w_state_next = r_state;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = a ? GOT_A : IDLE;
                end
                GOT_A: begin
                    // b completes the second step before a can restart.
                    if (b)      w_state_next = GOT_AB;
                    else if (a) w_state_next = GOT_A;
                    else        w_state_next = IDLE;
                end
                GOT_AB: begin
                    // An unknown y evaluates false here, so it never matches.
                    if (c && y) w_x_next = 1'b1;
                    // With or without c, a concurrent a restarts the pattern.
                    w_state_next = a ? GOT_A : IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

endmodule : seq_1
`default_nettype wire

// File: tb/tb_seq_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_1
//  Description : Self-checking bench for seq_1: directed vector table,
//                asynchronous reset sequences and randomized traffic against
//                a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_1;

    logic clk;
    logic rst_n;
    logic a, b, c, d, e, y;
    logic x;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: how many pattern steps have been seen (0, 1 or 2) and x.
    int   m_prog = 0;
    logic m_x    = 1'b0;

    typedef struct {
        logic       a, b, c, d, e, y;
        logic       exp_x;
        logic [1:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    seq_1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .y     (y),
        .x     (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_st(input string name, input logic [1:0] exp);
        logic [1:0] act;
        act = dut.r_state;
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: state got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Apply the sequencing rules to one clock edge with the current inputs.
    task automatic model_edge();
        logic nx;
        int   np;
        nx = 1'b0;
        np = m_prog;
        if (!rst_n || e) begin
            np = 0;
        end else if (!d) begin
            if (m_prog == 2 && c && y === 1'b1) nx = 1'b1;
            if (m_prog == 1 && b)               np = 2;
            else                                np = a ? 1 : 0;
        end
        m_prog = np;
        m_x    = nx;
    endtask

    // Drive inputs (at a falling edge), clock once, land on the next falling edge.
    task automatic step(input logic ia, ib, ic, id, ie, iy);
        a = ia; b = ib; c = ic; d = id; e = ie; y = iy;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic ia, ib, ic, id, ie, iy, ex, input logic [1:0] es);
        vec_t v;
        v.a = ia; v.b = ib; v.c = ic; v.d = id; v.e = ie; v.y = iy;
        v.exp_x = ex; v.exp_st = es;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        a = 0; b = 0; c = 0; d = 0; e = 0; y = 0;

        // ---- reset ----
        repeat (2) @(negedge clk);
        check_bit("reset_x", x, 1'b0);
        check_st("reset_state", 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check_bit("idle_x", x, 1'b0);
        end
        check_st("idle_state", 2'd0);

        // ---- directed vector table: a b c d e y | x state ----
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        add(0,0,1,0,0,1, 1, 2'd0);
        for (int i = 0; i < 5; i++) add(1,0,0,0,0,0, 0, 2'd1);
        add(0,0,0,0,0,0, 0, 2'd0);
        // unqualified completion
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,0, 0, 2'd2);
        add(0,0,1,0,0,0, 0, 2'd0);
        // stall holds GOT_AB
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        for (int i = 0; i < 3; i++) add(0,0,1,1,0,1, 0, 2'd2);
        add(0,0,1,0,0,1, 1, 2'd0);
        add(0,0,0,0,0,0, 0, 2'd0);
        // clear before c, then clear together with c
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        add(0,0,0,0,1,0, 0, 2'd0);
        add(0,0,1,0,0,1, 0, 2'd0);
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        add(0,0,1,0,1,1, 0, 2'd0);
        // back-to-back through restart
        add(1,0,0,0,0,0, 0, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        add(1,0,1,0,0,1, 1, 2'd1);
        add(0,1,0,0,0,1, 0, 2'd2);
        add(0,0,1,0,0,1, 1, 2'd0);
        add(0,0,0,0,0,0, 0, 2'd0);

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e, tbl[i].y);
            check_bit($sformatf("tbl%0d_x", i), x, tbl[i].exp_x);
            check_st($sformatf("tbl%0d_state", i), tbl[i].exp_st);
            check_bit($sformatf("tbl%0d_model", i), x, m_x);
        end

        // ---- reset between b and c aborts the pattern ----
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 check_bit("abort_x_now", x, 1'b0);
        check_st("abort_state_now", 2'd0);
        m_prog = 0; m_x = 1'b0;
        a = 0; b = 0; c = 1; y = 1;
        @(posedge clk);
        @(negedge clk);
        check_bit("abort_no_pulse", x, 1'b0);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 0, 1);
        check_bit("abort_c_after_release", x, 1'b0);

        // ---- reset drops a live pulse without a clock edge ----
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        check_bit("pulse_before_reset", x, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_bit("pulse_cleared_async", x, 1'b0);
        m_prog = 0; m_x = 1'b0;
        a = 0; b = 0; c = 0; y = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0));
            check_bit("rand_x", x, m_x);
            check_st("rand_state", m_prog[1:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_1
`default_nettype wire
